// File: rtl/mul_issue_ctrl_if.sv
// Request, multiplier and result-broadcast signals of the shared multiply issue controller.
// master = reservation stations, external multiplier and CDB; slave = the controller.
interface mul_issue_ctrl_if #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 4
);
  logic [NREQ-1:0]       req;
  logic [NREQ*32-1:0]    req_a;
  logic [NREQ*32-1:0]    req_b;
  logic [NREQ*TAG_W-1:0] req_tag;
  logic [NREQ-1:0]       grant;
  logic [31:0]           mul_a;
  logic [31:0]           mul_b;
  logic [63:0]           mul_p;
  logic                  cdb_valid;
  logic                  cdb_ready;
  logic [TAG_W-1:0]      cdb_tag;
  logic [63:0]           cdb_data;
  logic                  busy;

  modport master (
    output req, req_a, req_b, req_tag, mul_p, cdb_ready,
    input  grant, mul_a, mul_b, cdb_valid, cdb_tag, cdb_data, busy
  );

  modport slave (
    input  req, req_a, req_b, req_tag, mul_p, cdb_ready,
    output grant, mul_a, mul_b, cdb_valid, cdb_tag, cdb_data, busy
  );
endinterface

// File: rtl/mul_issue_ctrl.sv
// Round-robin issue of one multiply at a time onto a shared combinational multiplier,
// LAT-cycle multicycle hold, product broadcast on the CDB with valid/ready; next op may issue on the handshake.
module mul_issue_ctrl #(
  parameter int NREQ  = 4,
  parameter int TAG_W = 4,
  parameter int LAT   = 3
) (
  input  logic             clk,
  input  logic             rst,
  mul_issue_ctrl_if.slave  bus_if
);

  localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    DONE    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        a_q, a_d;
  logic [31:0]        b_q, b_d;
  logic [TAG_W-1:0]   tag_q, tag_d;
  logic [63:0]        data_q, data_d;

  logic               win_vld;
  logic [PTR_W-1:0]   win_idx;
  int                 scan;
  logic               issue;

  // Scan ptr, ptr+1, ... with wrap; first requesting station wins.
  always_comb begin
    win_vld = 1'b0;
    win_idx = '0;
    scan    = 0;
    for (int i = 0; i < NREQ; i++) begin
      scan = int'(ptr_q) + i;
      if (scan >= NREQ) begin
        scan = scan - NREQ;
      end
      if (!win_vld && bus_if.req[scan]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(scan);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    tag_d   = tag_q;
    data_d  = data_q;
    issue   = 1'b0;

    case (state_q)
      IDLE: begin
        issue = win_vld;
      end
      COMPUTE: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
        end else begin
          data_d  = bus_if.mul_p;
          state_d = DONE;
        end
      end
      DONE: begin
        if (bus_if.cdb_ready) begin
          state_d = IDLE;
          issue   = win_vld;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Shared by IDLE and the back-to-back handshake in DONE.
    if (issue) begin
      a_d     = bus_if.req_a[int'(win_idx)*32 +: 32];
      b_d     = bus_if.req_b[int'(win_idx)*32 +: 32];
      tag_d   = bus_if.req_tag[int'(win_idx)*TAG_W +: TAG_W];
      cnt_d   = CNT_W'(LAT - 1);
      state_d = COMPUTE;
      ptr_d   = (win_idx == PTR_W'(NREQ - 1)) ? '0 : win_idx + PTR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      tag_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      tag_q   <= tag_d;
      data_q  <= data_d;
    end
  end

  assign bus_if.grant     = issue ? (NREQ'(1) << win_idx) : '0;
  assign bus_if.mul_a     = a_q;
  assign bus_if.mul_b     = b_q;
  assign bus_if.cdb_valid = (state_q == DONE);
  assign bus_if.cdb_tag   = tag_q;
  assign bus_if.cdb_data  = data_q;
  assign bus_if.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Directed bench for mul_issue_ctrl with NREQ=4, TAG_W=4, LAT=3; the bench supplies the multiplier.
module tb_mul_issue_ctrl;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  mul_issue_ctrl_if #(.NREQ(4), .TAG_W(4)) bus_if ();

  mul_issue_ctrl #(.NREQ(4), .TAG_W(4), .LAT(3)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus_if (bus_if)
  );

  assign bus_if.mul_p = {32'd0, bus_if.mul_a} * {32'd0, bus_if.mul_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    bus_if.req_a[32*i +: 32] = a;
    bus_if.req_b[32*i +: 32] = b;
    bus_if.req_tag[4*i +: 4] = tag;
  endtask

  // Call right after a negedge; returns at negedge+1 of the first cycle with cdb_valid high.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      #1;
      if (bus_if.cdb_valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus_if.req = '0;
    bus_if.req_a = '0;
    bus_if.req_b = '0;
    bus_if.req_tag = '0;
    bus_if.cdb_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0 || bus_if.busy !== 1'b0 || bus_if.cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_ctrl: grant=%b busy=%b valid=%b, need 0/0/0", bus_if.grant, bus_if.busy, bus_if.cdb_valid);
    end
    n_cmp++;
    if (bus_if.mul_a !== 32'd0 || bus_if.mul_b !== 32'd0 || bus_if.cdb_tag !== 4'd0 || bus_if.cdb_data !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_data: a=%h b=%h tag=%h data=%h, need all 0", bus_if.mul_a, bus_if.mul_b, bus_if.cdb_tag, bus_if.cdb_data);
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.grant !== 4'b0) begin
      n_fail++;
      $display("FAIL idle_no_req: busy=%b grant=%b, need 0/0000", bus_if.busy, bus_if.grant);
    end
  endtask

  task automatic test_single_op;
    @(negedge clk);
    set_op(0, 32'd7, 32'd9, 4'd3);
    bus_if.req = 4'b0001;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_grant: got %b need 0001", bus_if.grant);
    end
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      bus_if.req = '0;
      #1;
      if (k == 1) begin
        n_cmp++;
        if (bus_if.mul_a !== 32'd7 || bus_if.mul_b !== 32'd9 || bus_if.busy !== 1'b1) begin
          n_fail++;
          $display("FAIL single_operands: a=%0d b=%0d busy=%b need 7/9/1", bus_if.mul_a, bus_if.mul_b, bus_if.busy);
        end
      end
      if (k < 4) begin
        n_cmp++;
        if (bus_if.cdb_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL single_early_valid: valid=1 at T+%0d, need 0", k);
        end
      end else begin
        n_cmp++;
        if (bus_if.cdb_valid !== 1'b1 || bus_if.cdb_tag !== 4'd3 || bus_if.cdb_data !== 64'd63) begin
          n_fail++;
          $display("FAIL single_result: valid=%b tag=%0d data=%0d, need 1/3/63 at T+4", bus_if.cdb_valid, bus_if.cdb_tag, bus_if.cdb_data);
        end
      end
    end
    bus_if.cdb_ready = 1'b1;
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
    #1;
    n_cmp++;
    if (bus_if.cdb_valid !== 1'b0 || bus_if.busy !== 1'b0) begin
      n_fail++;
      $display("FAIL single_release: valid=%b busy=%b need 0/0", bus_if.cdb_valid, bus_if.busy);
    end
  endtask

  task automatic test_max_operands;
    bit ok;
    @(negedge clk);
    set_op(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd5);
    bus_if.req = 4'b0010;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL max_grant: got %b need 0010", bus_if.grant);
    end
    @(negedge clk);
    bus_if.req = '0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || bus_if.cdb_tag !== 4'd5 || bus_if.cdb_data !== 64'hFFFF_FFFE_0000_0001) begin
      n_fail++;
      $display("FAIL max_result: ok=%0d tag=%0d data=%h need tag 5 data fffffffe00000001", ok, bus_if.cdb_tag, bus_if.cdb_data);
    end
    bus_if.cdb_ready = 1'b1;
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
  endtask

  task automatic test_backpressure;
    bit ok;
    @(negedge clk);
    set_op(2, 32'd1234, 32'd5678, 4'd9);
    bus_if.req = 4'b0100;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL bp_grant: got %b need 0100", bus_if.grant);
    end
    @(negedge clk);
    bus_if.req = '0;
    wait_valid(ok);
    bus_if.req = 4'b0001;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      #1;
      n_cmp++;
      if (!ok || bus_if.cdb_valid !== 1'b1 || bus_if.cdb_tag !== 4'd9 || bus_if.cdb_data !== 64'd7006652 ||
          bus_if.grant !== 4'b0 || bus_if.busy !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold[%0d]: valid=%b tag=%0d data=%0d grant=%b busy=%b need 1/9/7006652/0000/1",
                 k, bus_if.cdb_valid, bus_if.cdb_tag, bus_if.cdb_data, bus_if.grant, bus_if.busy);
      end
    end
    @(negedge clk);
    bus_if.cdb_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL bp_b2b_grant: got %b need 0001", bus_if.grant);
    end
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
    bus_if.req = '0;
    #1;
    n_cmp++;
    if (bus_if.cdb_valid !== 1'b0 || bus_if.busy !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_single_handshake: valid=%b busy=%b need 0/1", bus_if.cdb_valid, bus_if.busy);
    end
    @(negedge clk);
    wait_valid(ok);
    n_cmp++;
    if (!ok || bus_if.cdb_tag !== 4'd3 || bus_if.cdb_data !== 64'd63) begin
      n_fail++;
      $display("FAIL bp_next_result: ok=%0d tag=%0d data=%0d need 3/63", ok, bus_if.cdb_tag, bus_if.cdb_data);
    end
    bus_if.cdb_ready = 1'b1;
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    bit ok;
    int seen;
    @(negedge clk);
    set_op(1, 32'd100, 32'd200, 4'd7);
    bus_if.req = 4'b0010;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0010) begin
      n_fail++;
      $display("FAIL rstmid_grant: got %b need 0010", bus_if.grant);
    end
    @(negedge clk);
    bus_if.req = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.mul_a !== 32'd0 || bus_if.mul_b !== 32'd0 ||
        bus_if.cdb_valid !== 1'b0 || bus_if.cdb_tag !== 4'd0) begin
      n_fail++;
      $display("FAIL rstmid_async: busy=%b a=%0d b=%0d valid=%b tag=%0d need all 0",
               bus_if.busy, bus_if.mul_a, bus_if.mul_b, bus_if.cdb_valid, bus_if.cdb_tag);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (bus_if.cdb_valid !== 1'b0) seen++;
    end
    n_cmp++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL rstmid_no_bcast: valid seen %0d cycles need 0", seen);
    end
    @(negedge clk);
    set_op(2, 32'd3, 32'd5, 4'hA);
    bus_if.req = 4'b0100;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL rstmid_regrant: got %b need 0100", bus_if.grant);
    end
    @(negedge clk);
    bus_if.req = '0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || bus_if.cdb_tag !== 4'hA || bus_if.cdb_data !== 64'd15) begin
      n_fail++;
      $display("FAIL rstmid_result: ok=%0d tag=%h data=%0d need a/15", ok, bus_if.cdb_tag, bus_if.cdb_data);
    end
    bus_if.cdb_ready = 1'b1;
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
  endtask

  task automatic test_wrap;
    bit ok;
    @(negedge clk);
    set_op(3, 32'h0001_0000, 32'h0001_0000, 4'hC);
    set_op(0, 32'd7, 32'd9, 4'd3);
    bus_if.req = 4'b1001;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b1000) begin
      n_fail++;
      $display("FAIL wrap_first: got %b need 1000", bus_if.grant);
    end
    @(negedge clk);
    bus_if.req = 4'b0001;
    wait_valid(ok);
    n_cmp++;
    if (!ok || bus_if.cdb_tag !== 4'hC || bus_if.cdb_data !== 64'h0000_0001_0000_0000) begin
      n_fail++;
      $display("FAIL wrap_result: ok=%0d tag=%h data=%h need c/0000000100000000", ok, bus_if.cdb_tag, bus_if.cdb_data);
    end
    bus_if.cdb_ready = 1'b1;
    #1;
    n_cmp++;
    if (bus_if.grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL wrap_second: got %b need 0001", bus_if.grant);
    end
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
    bus_if.req = '0;
    wait_valid(ok);
    n_cmp++;
    if (!ok || bus_if.cdb_tag !== 4'd3 || bus_if.cdb_data !== 64'd63) begin
      n_fail++;
      $display("FAIL wrap_second_result: ok=%0d tag=%0d data=%0d need 3/63", ok, bus_if.cdb_tag, bus_if.cdb_data);
    end
    bus_if.cdb_ready = 1'b1;
    @(negedge clk);
    bus_if.cdb_ready = 1'b0;
  endtask

  task automatic test_fairness;
    int gidx [5];
    int gcyc [5];
    int n;
    int gi;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 32'(i + 2), 32'd10, 4'(i + 4));
    bus_if.req = 4'b1111;
    bus_if.cdb_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 40 && n < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      if (bus_if.grant !== 4'b0) begin
        gi = -1;
        for (int j = 0; j < 4; j++) if (bus_if.grant === (4'b0001 << j)) gi = j;
        gidx[n] = gi;
        gcyc[n] = c;
        n++;
      end
    end
    @(negedge clk);
    bus_if.req = '0;
    n_cmp++;
    if (n != 5) begin
      n_fail++;
      $display("FAIL fair_count: got %0d grants need 5", n);
    end
    for (int k = 0; k < n; k++) begin
      n_cmp++;
      if (gidx[k] != (k % 4)) begin
        n_fail++;
        $display("FAIL fair_order[%0d]: station %0d need %0d", k, gidx[k], k % 4);
      end
      if (k > 0) begin
        n_cmp++;
        if (gcyc[k] - gcyc[k-1] != 4) begin
          n_fail++;
          $display("FAIL fair_interval[%0d]: %0d cycles need 4", k, gcyc[k] - gcyc[k-1]);
        end
      end
    end
    for (int k = 0; k < 8; k++) @(negedge clk);
    #1;
    n_cmp++;
    if (bus_if.busy !== 1'b0 || bus_if.cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fair_drain: busy=%b valid=%b need 0/0", bus_if.busy, bus_if.cdb_valid);
    end
    bus_if.cdb_ready = 1'b0;
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    test_reset();
    test_single_op();
    test_max_operands();
    test_backpressure();
    test_reset_mid();
    test_wrap();
    test_fairness();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
